// File: rtl/writeback_regfile.sv
// writeback_regfile: register file written from S3 writeback, two registered read ports, retired-write counter.
// Define WRITEBACK_REGFILE_BYPASS_EN to return same-edge write data on a matching read.
module writeback_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              S3_WriteEnable,
  input  logic [ADDR_W-1:0] S3_WriteSelect,
  input  logic [DATA_W-1:0] S3_ALUOp_Out,
  input  logic              ReadEnable,
  input  logic [ADDR_W-1:0] ReadSelect1,
  input  logic [ADDR_W-1:0] ReadSelect2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [CNT_W-1:0]  WriteCount
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr;
  logic [DATA_W-1:0] rd1, rd2;
  // regs[0] is never written, so it stays zero after reset
  assign wr = S3_WriteEnable && S3_WriteSelect != '0;
`ifdef WRITEBACK_REGFILE_BYPASS_EN
  assign rd1 = (wr && S3_WriteSelect == ReadSelect1) ? S3_ALUOp_Out : regs[ReadSelect1];
  assign rd2 = (wr && S3_WriteSelect == ReadSelect2) ? S3_ALUOp_Out : regs[ReadSelect2];
`else
  assign rd1 = regs[ReadSelect1];
  assign rd2 = regs[ReadSelect2];
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      ReadData1  <= '0;
      ReadData2  <= '0;
      WriteCount <= '0;
    end else begin
      if (wr) begin
        regs[S3_WriteSelect] <= S3_ALUOp_Out;
        WriteCount           <= WriteCount + CNT_W'(1);
      end
      if (ReadEnable) begin
        ReadData1 <= rd1;
        ReadData2 <= rd2;
      end
    end
  end
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: directed plus random checks of writeback_regfile against an array model.
module tb_writeback_regfile;
  logic        clk = 0, rst = 1;
  logic        we = 0, re = 0;
  logic [4:0]  ws = 0, rs1 = 0, rs2 = 0;
  logic [31:0] wd = 0;
  logic [31:0] rd1, rd2, wc, rd1b, rd2b;
  logic [3:0]  wc4;
  int          passed = 0, total = 0;
  logic [31:0] m [32];
  logic [31:0] mr1 = 0, mr2 = 0, mcnt = 0;
  initial foreach (m[i]) m[i] = 0;
  always #5 clk = ~clk;
  writeback_regfile dut (
    .clk(clk), .rst(rst), .S3_WriteEnable(we), .S3_WriteSelect(ws), .S3_ALUOp_Out(wd),
    .ReadEnable(re), .ReadSelect1(rs1), .ReadSelect2(rs2),
    .ReadData1(rd1), .ReadData2(rd2), .WriteCount(wc));
  writeback_regfile #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .S3_WriteEnable(we), .S3_WriteSelect(ws), .S3_ALUOp_Out(wd),
    .ReadEnable(re), .ReadSelect1(rs1), .ReadSelect2(rs2),
    .ReadData1(rd1b), .ReadData2(rd2b), .WriteCount(wc4));
  // Model: reads see pre-write contents, patched with write data when bypass is built in
  always @(posedge clk or posedge rst)
    if (rst) begin
      foreach (m[i]) m[i] = 0;
      mr1 = 0; mr2 = 0; mcnt = 0;
    end else begin
      if (re) begin
        mr1 = m[rs1];
        mr2 = m[rs2];
`ifdef WRITEBACK_REGFILE_BYPASS_EN
        if (we && ws != 0 && ws == rs1) mr1 = wd;
        if (we && ws != 0 && ws == rs2) mr2 = wd;
`endif
      end
      if (we && ws != 0) begin
        m[ws] = wd;
        mcnt = mcnt + 1;
      end
    end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", n, act, exp);
  endtask
  always @(negedge clk) begin
    chk("rd1", rd1, mr1);
    chk("rd2", rd2, mr2);
    chk("wc", wc, mcnt);
    chk("wc4", {28'd0, wc4}, mcnt % 16);
    chk("rd1_c4", rd1b, mr1);
  end
  task automatic cyc(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic r, input logic [4:0] s1, input logic [4:0] s2);
    we = w; ws = a; wd = d; re = r; rs1 = s1; rs2 = s2;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_rd1", rd1, 32'h0);
    chk("reset_wc", wc, 32'h0);
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 0);
    cyc(0, 0, 0, 1, 5, 5);
    chk("r5_read", rd1, 32'hDEADBEEF);
    chk("r5_wc", wc, 32'd1);
    #2 rst = 1;
    #1;
    chk("async_rd1", rd1, 32'h0);
    chk("async_rd2", rd2, 32'h0);
    chk("async_wc", wc, 32'h0);
    #3 rst = 0;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 1, 5, 0);
    chk("r5_cleared", rd1, 32'h0);
    cyc(1, 1, 32'h11111111, 0, 0, 0);
    cyc(1, 31, 32'hFFFFFFFF, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 31);
    chk("r1_read", rd1, 32'h11111111);
    chk("r31_read", rd2, 32'hFFFFFFFF);
    chk("wc_two", wc, 32'd2);
    cyc(1, 0, 32'h12345678, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("r0_p1", rd1, 32'h0);
    chk("r0_p2", rd2, 32'h0);
    chk("r0_wc", wc, 32'd2);
    cyc(1, 7, 32'hAAAA0000, 0, 0, 0);
    cyc(1, 7, 32'h0000BBBB, 1, 7, 7);
`ifdef WRITEBACK_REGFILE_BYPASS_EN
    chk("bypass_same_edge", rd1, 32'h0000BBBB);
`else
    chk("bypass_same_edge", rd1, 32'hAAAA0000);
`endif
    cyc(0, 0, 0, 1, 7, 0);
    chk("bypass_next", rd1, 32'h0000BBBB);
    chk("bypass_wc", wc, 32'd4);
    cyc(0, 0, 0, 1, 1, 1);
    chk("stall_pre", rd1, 32'h11111111);
    cyc(1, 1, 32'h22222222, 0, 3, 4);
    chk("stall_hold1", rd1, 32'h11111111);
    cyc(0, 0, 0, 0, 9, 9);
    chk("stall_hold2", rd1, 32'h11111111);
    cyc(0, 0, 0, 1, 1, 1);
    chk("stall_release", rd1, 32'h22222222);
    chk("stall_wc", wc, 32'd5);
    repeat (3) cyc(0, 3, 32'h55555555, 0, 0, 0);
    chk("we0_nocount", {28'd0, wc4}, 32'd5);
    for (int i = 0; i < 11; i++) cyc(1, 5'(i + 1), 32'(i) * 32'h01010101, 0, 0, 0);
    chk("wrap_wc4", {28'd0, wc4}, 32'd0);
    chk("wrap_wc", wc, 32'd16);
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
